// File: rtl/glyph_pkg.sv
// ============================================================================
// Module   : glyph_pkg
// Purpose  : Shared glyph geometry, colour word type and box-size helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package glyph_pkg;

  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 16;
  localparam int GLYPH_AW = 7;
  localparam int COLOR_W  = 16;

  typedef logic [COLOR_W-1:0] color_t;

  function automatic int box_w(input int scale_log2);
    return GLYPH_W << scale_log2;
  endfunction

  function automatic int box_h(input int scale_log2);
    return GLYPH_H << scale_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_delay.sv
// ============================================================================
// Module   : pipe_delay
// Purpose  : WIDTH x DEPTH register chain with a per-bit reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_first
        always_ff @(posedge clock or posedge reset) begin
          if (reset) stage[i] <= RST_VAL;
          else       stage[i] <= din;
        end
      end else begin : g_next
        always_ff @(posedge clock or posedge reset) begin
          if (reset) stage[i] <= RST_VAL;
          else       stage[i] <= stage[i-1];
        end
      end
    end
  endgenerate

  assign dout = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/glyph_pixel_gen.sv
// ============================================================================
// Module   : glyph_pixel_gen
// Purpose  : Drives a 128x1 glyph ROM from raster coordinates and emits one
//            scaled character box, realigned with delayed sync/DE (3 clocks).
//            Optional blink controlled by macro GLYPH_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glyph_pixel_gen
  import glyph_pkg::*;
#(
  parameter int                 ORG_X        = 100,
  parameter int                 ORG_Y        = 50,
  parameter int                 SCALE_LOG2   = 1,
  parameter int                 COLOR_W      = 16,
  parameter logic [COLOR_W-1:0] FG_COLOR     = 16'hFFFF,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 16'h0000,
  parameter logic               SYNC_IDLE    = 1'b1,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [10:0]         pix_x,
  input  logic [10:0]         pix_y,
  input  logic                pix_de,
  input  logic                hsync_in,
  input  logic                vsync_in,
  output logic [GLYPH_AW-1:0] rom_address,
  input  logic                rom_q,
  output logic [COLOR_W-1:0]  rgb_out,
  output logic                glyph_hit,
  output logic                de_out,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam logic [31:0] X_LO  = 32'(ORG_X);
  localparam logic [31:0] X_HI  = 32'(ORG_X + box_w(SCALE_LOG2));
  localparam logic [31:0] Y_LO  = 32'(ORG_Y);
  localparam logic [31:0] Y_HI  = 32'(ORG_Y + box_h(SCALE_LOG2));
  localparam logic [10:0] ORG_X11 = 11'(ORG_X);
  localparam logic [10:0] ORG_Y11 = 11'(ORG_Y);

  logic [31:0] x_wide;
  logic [31:0] y_wide;
  logic        in_box;
  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] dx_scaled;
  logic [10:0] dy_scaled;
  logic [2:0]  col;
  logic [3:0]  row;

  // Range check is done on the raw coordinates so the offsets below never
  // matter outside the box (their wrap is masked by in_box).
  assign x_wide    = {21'd0, pix_x};
  assign y_wide    = {21'd0, pix_y};
  assign in_box    = (x_wide >= X_LO) && (x_wide < X_HI) &&
                     (y_wide >= Y_LO) && (y_wide < Y_HI);
  assign dx        = pix_x - ORG_X11;
  assign dy        = pix_y - ORG_Y11;
  assign dx_scaled = dx >> SCALE_LOG2;
  assign dy_scaled = dy >> SCALE_LOG2;
  assign col       = dx_scaled[2:0];
  assign row       = dy_scaled[3:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rom_address <= '0;
    else       rom_address <= in_box ? {row, col} : '0;
  end

  logic s1_in_box;
  logic s1_de;
  logic s1_hsync;
  logic s1_vsync;

  pipe_delay #(
    .WIDTH   (4),
    .DEPTH   (2),
    .RST_VAL ({1'b0, 1'b0, SYNC_IDLE, SYNC_IDLE})
  ) u_sideband (
    .clock (clock),
    .reset (reset),
    .din   ({in_box, pix_de, hsync_in, vsync_in}),
    .dout  ({s1_in_box, s1_de, s1_hsync, s1_vsync})
  );

`ifdef GLYPH_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             vsync_prev;
  logic             visible;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt  <= '0;
      vsync_prev <= SYNC_IDLE;
      visible    <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if ((vsync_prev == SYNC_IDLE) && (vsync_in != SYNC_IDLE)) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          visible   <= ~visible;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic visible;
  assign visible = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb_out   <= '0;
      glyph_hit <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      if (!s1_de)                            rgb_out <= '0;
      else if (s1_in_box && rom_q && visible) rgb_out <= FG_COLOR;
      else                                   rgb_out <= BG_COLOR;
      glyph_hit <= s1_de & s1_in_box;
      de_out    <= s1_de;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_glyph_pixel_gen.sv
// ============================================================================
// Module   : tb_glyph_pixel_gen
// Purpose  : Directed self-checking bench for glyph_pixel_gen with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_glyph_pixel_gen;
  import glyph_pkg::*;

  localparam color_t FG = 16'hFFFF;
  localparam color_t BG = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] pix_x = '0;
  logic [10:0] pix_y = '0;
  logic        pix_de = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [6:0]  rom_address;
  logic        rom_q = 1'b0;
  color_t      rgb_out;
  logic        glyph_hit;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;

  int errors = 0;
  int checks = 0;

  // Bit 0 = 1, bits 40..47 = 8'hBA (row 5), bit 4 = 1, bit 127 = 0
  logic [127:0] rom_bits = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211;

  glyph_pixel_gen #(
    .ORG_X(100), .ORG_Y(50), .SCALE_LOG2(1), .COLOR_W(16),
    .FG_COLOR(FG), .BG_COLOR(BG), .SYNC_IDLE(1'b1), .BLINK_FRAMES(2)
  ) dut (
    .clock(clock), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .pix_de(pix_de), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rom_address(rom_address), .rom_q(rom_q), .rgb_out(rgb_out),
    .glyph_hit(glyph_hit), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom_bits[rom_address];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic de,
                       input logic hs, input logic vs);
    pix_x    = 11'(x);
    pix_y    = 11'(y);
    pix_de   = de;
    hsync_in = hs;
    vsync_in = vs;
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (rom_address !== 7'd0 || rgb_out !== 16'h0 || glyph_hit !== 1'b0 ||
        de_out !== 1'b0 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: addr=%0d rgb=%h hit=%b de=%b hs=%b vs=%b required 0 0 0 0 1 1",
               rom_address, rgb_out, glyph_hit, de_out, hsync_out, vsync_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_origin();
    drive(100, 50, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (rom_address !== 7'd0) begin
      errors++;
      $display("FAIL origin_addr: got %0d required 0", rom_address);
    end
    idle();
    tick();
    tick();
    checks++;
    if (rgb_out !== FG || glyph_hit !== 1'b1 || de_out !== 1'b1) begin
      errors++;
      $display("FAIL origin_pixel: rgb=%h hit=%b de=%b required %h 1 1",
               rgb_out, glyph_hit, de_out, FG);
    end
  endtask

  task automatic test_corners();
    int     vx   [4] = '{115, 99, 116, 100};
    int     vy   [4] = '{81, 50, 50, 82};
    int     va   [4] = '{127, 0, 0, 0};
    logic   vh   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    color_t exp_rgb;
    for (int k = 0; k < 4; k++) begin
      drive(vx[k], vy[k], 1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (rom_address !== 7'(va[k])) begin
        errors++;
        $display("FAIL corner_addr(%0d,%0d): got %0d required %0d",
                 vx[k], vy[k], rom_address, va[k]);
      end
      idle();
      tick();
      tick();
      exp_rgb = (vh[k] && rom_bits[va[k]]) ? FG : BG;
      checks++;
      if (glyph_hit !== vh[k] || rgb_out !== exp_rgb) begin
        errors++;
        $display("FAIL corner_pixel(%0d,%0d): hit=%b rgb=%h required %b %h",
                 vx[k], vy[k], glyph_hit, rgb_out, vh[k], exp_rgb);
      end
    end
  endtask

  task automatic test_row_scan();
    int     a;
    color_t exp_rgb;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) drive(100 + i, 60, 1'b1, 1'b1, 1'b1);
      else        idle();
      tick();
      if (i < 16) begin
        checks++;
        if (rom_address !== 7'(40 + i / 2)) begin
          errors++;
          $display("FAIL scan_addr x=%0d: got %0d required %0d",
                   100 + i, rom_address, 40 + i / 2);
        end
      end
      if (i >= 2) begin
        a = 40 + (i - 2) / 2;
        exp_rgb = rom_bits[a] ? FG : BG;
        checks++;
        if (rgb_out !== exp_rgb || glyph_hit !== 1'b1) begin
          errors++;
          $display("FAIL scan_pixel x=%0d: rgb=%h hit=%b required %h 1",
                   100 + i - 2, rgb_out, glyph_hit, exp_rgb);
        end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_sync_blank();
    logic hs;
    logic exp_hs;
    int   low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      hs = (i >= 2 && i < 6) ? 1'b0 : 1'b1;
      drive(105, 60, 1'b0, hs, 1'b1);
      tick();
      if (i >= 2) begin
        exp_hs = (i - 2 >= 2 && i - 2 < 6) ? 1'b0 : 1'b1;
        if (hsync_out == 1'b0) low_cnt++;
        checks++;
        if (hsync_out !== exp_hs || rgb_out !== 16'h0 || de_out !== 1'b0 ||
            glyph_hit !== 1'b0) begin
          errors++;
          $display("FAIL sync_blank step %0d: hs=%b rgb=%h de=%b hit=%b required %b 0000 0 0",
                   i, hsync_out, rgb_out, de_out, glyph_hit, exp_hs);
        end
      end
    end
    checks++;
    if (low_cnt != 4) begin
      errors++;
      $display("FAIL hsync_width: got %0d low clocks required 4", low_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      drive(100 + i, 50, 1'b1, 1'b0, 1'b1);
      tick();
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (rom_address !== 7'd0 || rgb_out !== 16'h0 || glyph_hit !== 1'b0 ||
        de_out !== 1'b0 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: addr=%0d rgb=%h hit=%b de=%b hs=%b vs=%b required 0 0 0 0 1 1",
               rom_address, rgb_out, glyph_hit, de_out, hsync_out, vsync_out);
    end
    tick();
    reset = 1'b0;
    drive(108, 50, 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (rom_address !== 7'd4) begin
      errors++;
      $display("FAIL post_reset_addr: got %0d required 4", rom_address);
    end
    idle();
    tick();
    checks++;
    if (glyph_hit !== 1'b0 || rgb_out !== 16'h0) begin
      errors++;
      $display("FAIL post_reset_early: hit=%b rgb=%h required 0 0000", glyph_hit, rgb_out);
    end
    tick();
    checks++;
    if (glyph_hit !== 1'b1 || rgb_out !== FG) begin
      errors++;
      $display("FAIL post_reset_first: hit=%b rgb=%h required 1 %h", glyph_hit, rgb_out, FG);
    end
  endtask

`ifdef GLYPH_BLINK_EN
  task automatic test_blink();
    color_t exp_rgb;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) begin
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
      end
      drive(108, 50, 1'b1, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      tick();
      exp_rgb = (f == 2 || f == 3) ? BG : FG;
      checks++;
      if (rgb_out !== exp_rgb || glyph_hit !== 1'b1) begin
        errors++;
        $display("FAIL blink frame %0d: rgb=%h hit=%b required %h 1",
                 f, rgb_out, glyph_hit, exp_rgb);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_origin();
    test_corners();
    test_row_scan();
    test_sync_blank();
    test_reset_midstream();
`ifdef GLYPH_BLINK_EN
    test_blink();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
